pca_cov_seq_ctrl: RTL and testbench

//  Sequencer for the PCA covariance stage. Walks every upper-triangular feature pair (i,j), j>=i.
//  For each pair: streams all samples out of the sample buffer into the shared MAC datapath,

---
 rtl/pca_pkg.sv | 21 ++
 rtl/pca_cov_seq_ctrl_if.sv | 30 +++
 rtl/pca_pair_iter.sv | 46 ++++
 rtl/pca_cov_seq_ctrl.sv | 119 +++++++++++
 tb/tb_pca_cov_seq_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pca_pkg.sv
// Shared definitions for the PCA covariance sequencer.
//   pca_state_e   : controller state encoding (IDLE, READ, DRAIN, WRITE, DONE)
//   pca_num_pairs : number of upper-triangular feature pairs for n_feat features
//   PERF_W        : width of the optional busy-cycle counter
package pca_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } pca_state_e;

    localparam int PERF_W = 32;

    function automatic int pca_num_pairs(input int n_feat);
        return n_feat * (n_feat + 1) / 2;
    endfunction

endpackage

// File: rtl/pca_cov_seq_ctrl_if.sv
// Sequencer <-> sample buffer / MAC / covariance store signals.
//   master : driven by the sequencer (read strobe, indices, MAC control, result valid)
//   slave  : buffer/MAC/store side (drives res_ready)
interface pca_cov_seq_ctrl_if #(
    parameter int SAMPLE_AW = 6,
    parameter int FEAT_AW   = 2,
    parameter int PAIR_AW   = 4
);
    logic                 rd_en;
    logic [SAMPLE_AW-1:0] sample_addr;
    logic [FEAT_AW-1:0]   feat_i;
    logic [FEAT_AW-1:0]   feat_j;
    logic                 mac_valid;
    logic                 mac_clear;
    logic                 res_valid;
    logic                 res_ready;
    logic [PAIR_AW-1:0]   res_addr;

    modport master (
        output rd_en, sample_addr, feat_i, feat_j, mac_valid, mac_clear,
               res_valid, res_addr,
        input  res_ready
    );

    modport slave (
        input  rd_en, sample_addr, feat_i, feat_j, mac_valid, mac_clear,
               res_valid, res_addr,
        output res_ready
    );
endinterface

// File: rtl/pca_pair_iter.sv
// Upper-triangular (i,j) pair index generator, j >= i, row-major.
//   clear   : return to pair (0,0), linear index 0
//   advance : step to next pair (caller never advances past the last pair)
//   i, j    : current pair indices
//   pair    : linear pair index
//   last    : current pair is (N_FEAT-1, N_FEAT-1)
module pca_pair_iter #(
    parameter int N_FEAT  = 4,
    parameter int FEAT_AW = 2,
    parameter int PAIR_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    output logic [FEAT_AW-1:0] i,
    output logic [FEAT_AW-1:0] j,
    output logic [PAIR_AW-1:0] pair,
    output logic               last
);
    localparam logic [FEAT_AW-1:0] F_LAST = FEAT_AW'(N_FEAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i    <= '0;
            j    <= '0;
            pair <= '0;
        end else if (clear) begin
            i    <= '0;
            j    <= '0;
            pair <= '0;
        end else if (advance) begin
            pair <= pair + 1'b1;
            if (j != F_LAST) begin
                j <= j + 1'b1;
            end else begin
                // next row starts on its diagonal
                i <= i + 1'b1;
                j <= i + 1'b1;
            end
        end
    end

    assign last = (i == F_LAST) && (j == F_LAST);

endmodule

// File: rtl/pca_cov_seq_ctrl.sv
// PCA covariance stage sequencer. For every upper-triangular feature pair it
// streams N_SAMPLES samples into the MAC, waits 1+MAC_LAT cycles for the
// buffer read and MAC pipeline to drain, then offers the result to the store.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle start request (ignored while busy)
//   busy        : state != IDLE
//   done        : one-cycle pulse after the last pair is accepted
//   bus         : buffer/MAC/store signals (master side)
//   busy_cycles : busy-cycle counter, present only when PCA_PERF_CNT_EN is defined
module pca_cov_seq_ctrl
    import pca_pkg::*;
#(
    parameter int N_SAMPLES = 64,
    parameter int N_FEAT    = 4,
    parameter int SAMPLE_AW = 6,
    parameter int FEAT_AW   = 2,
    parameter int PAIR_AW   = 4,
    parameter int MAC_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
`ifdef PCA_PERF_CNT_EN
    output logic [PERF_W-1:0] busy_cycles,
`endif
    pca_cov_seq_ctrl_if.master bus
);
    localparam int                   DRAIN_W = $clog2(MAC_LAT + 1);
    localparam logic [SAMPLE_AW-1:0] K_LAST  = SAMPLE_AW'(N_SAMPLES - 1);
    localparam logic [DRAIN_W-1:0]   D_LAST  = DRAIN_W'(MAC_LAT);

    pca_state_e           state, state_nxt;
    logic [SAMPLE_AW-1:0] k;
    logic [DRAIN_W-1:0]   dcnt;
    logic                 iter_clear, iter_adv, iter_last;
    logic                 rd_en;

    pca_pair_iter #(
        .N_FEAT (N_FEAT),
        .FEAT_AW(FEAT_AW),
        .PAIR_AW(PAIR_AW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (iter_clear),
        .advance(iter_adv),
        .i      (bus.feat_i),
        .j      (bus.feat_j),
        .pair   (bus.res_addr),
        .last   (iter_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        iter_clear = 1'b0;
        iter_adv   = 1'b0;
        case (state)
            S_IDLE:  if (start) begin
                         state_nxt  = S_READ;
                         iter_clear = 1'b1;
                     end
            S_READ:  if (k == K_LAST) state_nxt = S_DRAIN;
            S_DRAIN: if (dcnt == D_LAST) state_nxt = S_WRITE;
            S_WRITE: if (bus.res_ready) begin
                         if (iter_last) begin
                             state_nxt = S_DONE;
                         end else begin
                             state_nxt = S_READ;
                             iter_adv  = 1'b1;
                         end
                     end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rd_en = (state == S_READ);

    // k and dcnt rest at 0 outside their own states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k             <= '0;
            dcnt          <= '0;
            bus.mac_valid <= 1'b0;
            bus.mac_clear <= 1'b0;
        end else begin
            if (state == S_READ)  k    <= (k == K_LAST) ? '0 : k + 1'b1;
            if (state == S_DRAIN) dcnt <= (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
            // buffer data arrives one cycle after the read strobe
            bus.mac_valid <= rd_en;
            bus.mac_clear <= rd_en && (k == '0);
        end
    end

`ifdef PCA_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cycles <= '0;
        else if (state == S_IDLE && start)
            busy_cycles <= '0;
        else if (state != S_IDLE && busy_cycles != {PERF_W{1'b1}})
            busy_cycles <= busy_cycles + 1'b1;
    end
`endif

    assign bus.rd_en       = rd_en;
    assign bus.sample_addr = k;
    assign bus.res_valid   = (state == S_WRITE);
    assign busy            = (state != S_IDLE);
    assign done            = (state == S_DONE);

endmodule

// File: tb/tb_pca_cov_seq_ctrl.sv
// Directed bench for pca_cov_seq_ctrl: N_SAMPLES=8, N_FEAT=2, MAC_LAT=2.
// Each pair takes 12 cycles (8 READ, 3 DRAIN, 1 WRITE); done lands 37 cycles
// after the start cycle with res_ready held high.
module tb_pca_cov_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy, done;
`ifdef PCA_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int fi[3] = '{0, 0, 1};
    int fj[3] = '{0, 1, 1};
    int dc;

    always #5 clk = ~clk;

    pca_cov_seq_ctrl_if #(.SAMPLE_AW(3), .FEAT_AW(1), .PAIR_AW(2)) bus ();

    pca_cov_seq_ctrl #(
        .N_SAMPLES(8), .N_FEAT(2), .SAMPLE_AW(3),
        .FEAT_AW(1), .PAIR_AW(2), .MAC_LAT(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
`ifdef PCA_PERF_CNT_EN
        .busy_cycles(busy_cycles),
`endif
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, bus.rd_en, 0);
        chk({tag, "_addr"}, bus.sample_addr, 0);
        chk({tag, "_fi"}, bus.feat_i, 0);
        chk({tag, "_fj"}, bus.feat_j, 0);
        chk({tag, "_mvalid"}, bus.mac_valid, 0);
        chk({tag, "_mclear"}, bus.mac_clear, 0);
        chk({tag, "_rvalid"}, bus.res_valid, 0);
        chk({tag, "_raddr"}, bus.res_addr, 0);
    endtask

    // Pulses start, then walks cycle by cycle (cycle 1 = first cycle after
    // the start cycle). First WRITE is cycle 12; stall_len holds res_ready low
    // there. pulse_at re-pulses start mid-run. detailed enables the per-cycle
    // model (only meaningful with stall_len == 0).
    task automatic run_seq(input int stall_len, input int pulse_at, input bit detailed,
                           output int done_cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        for (int n = 1; n <= 100; n++) begin
            bus.res_ready = !(n >= 12 && n < 12 + stall_len);
            start = (n == pulse_at);
`ifdef PCA_PERF_CNT_EN
            if (n == 1) chk("perf_cleared", busy_cycles, 0);
`endif
            if (detailed && n <= 36) begin
                int p, off;
                p   = (n - 1) / 12;
                off = (n - 1) % 12;
                chk("rd_en", bus.rd_en, off < 8);
                chk("sample_addr", bus.sample_addr, off < 8 ? off : 0);
                chk("mac_valid", bus.mac_valid, off >= 1 && off <= 8);
                chk("mac_clear", bus.mac_clear, off == 1);
                chk("res_valid", bus.res_valid, off == 11);
                chk("res_addr", bus.res_addr, p);
                chk("feat_i", bus.feat_i, fi[p]);
                chk("feat_j", bus.feat_j, fj[p]);
                chk("busy", busy, 1);
                chk("done_early", done, 0);
            end
            if (stall_len > 0 && n >= 12 && n <= 12 + stall_len) begin
                chk("stall_rvalid", bus.res_valid, 1);
                chk("stall_raddr", bus.res_addr, 0);
                chk("stall_rd_en", bus.rd_en, 0);
            end
            if (done) begin
                done_cyc = n;
                chk("done_busy", busy, 1);
                @(posedge clk); #1;
                chk("after_done_busy", busy, 0);
                chk("after_done_pulse", done, 0);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.res_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
`ifdef PCA_PERF_CNT_EN
        chk("reset_perf", busy_cycles, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // res_ready ignored while idle
        chk("idle_ready_busy", busy, 0);

        // full run, per-cycle model
        run_seq(0, 0, 1'b1, dc);
        chk("done_cycle", dc, 37);
`ifdef PCA_PERF_CNT_EN
        chk("perf_count", busy_cycles, 37);
        repeat (3) @(posedge clk);
        #1;
        chk("perf_hold_idle", busy_cycles, 37);
`endif

        // five-cycle store stall on the first result
        repeat (2) @(posedge clk);
        #1;
        run_seq(5, 0, 1'b0, dc);
        chk("stall_done_cycle", dc, 42);

        // start pulse during pair 1 READ is ignored
        @(posedge clk); #1;
        run_seq(0, 15, 1'b0, dc);
        chk("busy_start_done_cycle", dc, 37);

        // start pulse on the done cycle is ignored: pulse lands at cycle 37
        @(posedge clk); #1;
        run_seq(0, 37, 1'b0, dc);
        chk("done_start_done_cycle", dc, 37);
        repeat (2) @(posedge clk);
        #1;
        chk("done_start_still_idle", busy, 0);

        // reset in DRAIN of pair 1 (cycles 21..23)
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("pre_reset_fj", bus.feat_j, 1);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_rd_en", bus.rd_en, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_seq(0, 0, 1'b1, dc);
        chk("post_reset_done_cycle", dc, 37);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
